// File: rtl/as1802_trace_pkg.sv
// Shared definitions for the AS1802 bus tracer: state codes, FSM states and
// the bit layout of a trace record {ts, sc, dir, n, addr_full, data}.
package as1802_trace_pkg;

  localparam logic [1:0] SC_FETCH = 2'b00;
  localparam logic [1:0] SC_EXEC  = 2'b01;
  localparam logic [1:0] SC_DMA   = 2'b10;
  localparam logic [1:0] SC_INT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_STROBE = 2'd2
  } trace_state_e;

  function automatic int rec_width(input int addr_w, input int data_w, input int ts_w);
    return ts_w + 2 + 1 + 3 + 2 * addr_w + data_w;
  endfunction

  // Fields are packed from the LSB upward: data, addr_full, n, dir, sc, ts.
  function automatic int rec_addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int rec_n_lsb(input int addr_w, input int data_w);
    return data_w + 2 * addr_w;
  endfunction

  function automatic int rec_dir_lsb(input int addr_w, input int data_w);
    return rec_n_lsb(addr_w, data_w) + 3;
  endfunction

  function automatic int rec_sc_lsb(input int addr_w, input int data_w);
    return rec_dir_lsb(addr_w, data_w) + 1;
  endfunction

  function automatic int rec_ts_lsb(input int addr_w, input int data_w);
    return rec_sc_lsb(addr_w, data_w) + 2;
  endfunction

endpackage

// File: rtl/as1802_bus_tracer_fifo.sv
// Generic synchronous first-word-fall-through FIFO; the output reads as zero
// when empty so a cleared FIFO presents an all-zero head.
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_fire;
  logic          rd_fire;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  // A push on full is only taken when the head leaves in the same cycle.
  assign wr_fire = push & (~full | pop);
  assign rd_fire = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/as1802_bus_tracer.sv
// Passive AS1802 memory-bus tracer: demultiplexes the address, classifies the
// access, timestamps it and queues completed transactions in a FWFT FIFO.
module as1802_bus_tracer
  import as1802_trace_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int REC_W  = rec_width(ADDR_W, DATA_W, TS_W)
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     cap_rd,
  input  logic                     cap_wr,
  input  logic                     tpa,
  input  logic                     mrd_n,
  input  logic                     mwr_n,
  input  logic [1:0]               sc,
  input  logic [2:0]               n,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        data,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [REC_W-1:0]         rec_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic                     proto_err,
  output logic [7:0]               drop_cnt,
  output logic [1:0]               state_dbg
);

  localparam int ADDR_LSB = rec_addr_lsb(DATA_W);
  localparam int N_LSB    = rec_n_lsb(ADDR_W, DATA_W);
  localparam int DIR_LSB  = rec_dir_lsb(ADDR_W, DATA_W);
  localparam int SC_LSB   = rec_sc_lsb(ADDR_W, DATA_W);
  localparam int TS_LSB   = rec_ts_lsb(ADDR_W, DATA_W);

  trace_state_e      state, state_nxt;
  logic [TS_W-1:0]   ts_cnt, ts_q;
  logic [ADDR_W-1:0] addr_hi, addr_lo;
  logic [1:0]        sc_q;
  logic [2:0]        n_q;
  logic              dir_q;
  logic [DATA_W-1:0] data_q;
  logic [REC_W-1:0]  rec;

  logic both_low, any_low, act_low;
  logic latch_hdr, latch_lo, hold_data, push, err;
  logic fifo_full, fifo_empty, pop, drop;

  assign both_low  = ~mrd_n & ~mwr_n;
  assign any_low   = ~mrd_n | ~mwr_n;
  assign act_low   = dir_q ? ~mwr_n : ~mrd_n;
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    latch_hdr = 1'b0;
    latch_lo  = 1'b0;
    hold_data = 1'b0;
    push      = 1'b0;
    err       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tpa && en) begin
          latch_hdr = 1'b1;
          state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (both_low) begin
          err       = 1'b1;
          state_nxt = ST_IDLE;
        end else if (any_low) begin
          latch_lo  = 1'b1;
          state_nxt = ST_STROBE;
        end else if (tpa) begin
          latch_hdr = 1'b1;   // non-memory cycle: the new TPA starts over
        end
      end
      ST_STROBE: begin
        if (both_low) begin
          err       = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tpa) begin
          err       = 1'b1;
          latch_hdr = 1'b1;
          state_nxt = ST_ADDR;
        end else if (act_low) begin
          hold_data = 1'b1;
        end else begin
          push      = dir_q ? cap_wr : cap_rd;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clr) begin
      state   <= ST_IDLE;
      ts_cnt  <= '0;
      ts_q    <= '0;
      addr_hi <= '0;
      addr_lo <= '0;
      sc_q    <= '0;
      n_q     <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state  <= state_nxt;
      ts_cnt <= ts_cnt + 1'b1;
      if (latch_hdr) begin
        addr_hi <= addr;
        ts_q    <= ts_cnt;
        sc_q    <= sc;
        n_q     <= n;
      end
      if (latch_lo) begin
        addr_lo <= addr;
        dir_q   <= ~mwr_n;
      end
      if (latch_lo || hold_data) data_q <= data;
    end
  end

  always_comb begin
    rec = '0;
    rec[0 +: DATA_W]          = data_q;
    rec[ADDR_LSB +: 2*ADDR_W] = {addr_hi, addr_lo};
    rec[N_LSB +: 3]           = n_q;
    rec[DIR_LSB]              = dir_q;
    rec[SC_LSB +: 2]          = sc_q;
    rec[TS_LSB +: TS_W]       = ts_q;
  end

  assign pop  = rec_valid & rec_ready;
  assign drop = push & fifo_full & ~pop;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clr) begin
      ovf       <= 1'b0;
      proto_err <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (err) proto_err <= 1'b1;
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  trace_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .clr   (clr),
    .push  (push),
    .wdata (rec),
    .pop   (pop),
    .rdata (rec_data),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rec_valid = ~fifo_empty;

endmodule

// File: tb/tb_as1802_bus_tracer.sv
// Bench for as1802_bus_tracer: drives bus cycles, predicts records into a
// queue and compares them as the FIFO is drained.
module tb_as1802_bus_tracer;
  import as1802_trace_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int TS_W   = 16;
  localparam int REC_W  = TS_W + 2 + 1 + 3 + 2 * ADDR_W + DATA_W;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              wb_clk_i, wb_rst_i, en, clr, cap_rd, cap_wr;
  logic              tpa, mrd_n, mwr_n, rec_valid, rec_ready;
  logic              ovf, proto_err;
  logic [1:0]        sc, state_dbg;
  logic [2:0]        n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [REC_W-1:0]  rec_data;
  logic [LW-1:0]     level;
  logic [7:0]        drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [REC_W-1:0] exp_q[$];
  logic [TS_W-1:0]  model_ts;

  as1802_bus_tracer #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .DEPTH (DEPTH), .TS_W (TS_W)
  ) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i), .en (en), .clr (clr),
    .cap_rd (cap_rd), .cap_wr (cap_wr), .tpa (tpa), .mrd_n (mrd_n),
    .mwr_n (mwr_n), .sc (sc), .n (n), .addr (addr), .data (data),
    .rec_valid (rec_valid), .rec_ready (rec_ready), .rec_data (rec_data),
    .level (level), .ovf (ovf), .proto_err (proto_err),
    .drop_cnt (drop_cnt), .state_dbg (state_dbg)
  );

  // clock / reset
  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge wb_clk_i) model_ts <= (wb_rst_i || clr) ? '0 : model_ts + 1'b1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted head record must match the oldest prediction
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && rec_valid && rec_ready) begin
      check_val("rec_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check_val("rec", rec_data, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      step();
      tpa = 1'b0; mrd_n = 1'b1; mwr_n = 1'b1; addr = '0; data = '0;
    end
  endtask

  task automatic access(input logic [7:0] hi, input logic [7:0] lo, input logic [1:0] s,
                        input logic [2:0] nn, input bit wr, input logic [7:0] d0,
                        input logic [7:0] d1, input int nlow, input bit exp_rec,
                        input bit pop_at_push);
    logic [TS_W-1:0] t;
    step();
    tpa = 1'b1; addr = hi; sc = s; n = nn; mrd_n = 1'b1; mwr_n = 1'b1;
    t = model_ts;
    for (int i = 0; i < nlow; i++) begin
      step();
      tpa = 1'b0; addr = lo; data = (i == nlow - 1) ? d1 : d0;
      if (wr) mwr_n = 1'b0; else mrd_n = 1'b0;
    end
    step();
    mrd_n = 1'b1; mwr_n = 1'b1; addr = '0; data = '0;
    if (pop_at_push) rec_ready = 1'b1;
    if (exp_rec) exp_q.push_back({t, s, wr, nn, hi, lo, d1});
    step();
    if (pop_at_push) rec_ready = 1'b0;
  endtask

  task automatic check_clean(input string pfx);
    check_val({pfx, "_rec_valid"}, rec_valid, 0);
    check_val({pfx, "_level"}, level, 0);
    check_val({pfx, "_rec_data"}, rec_data, 0);
    check_val({pfx, "_ovf"}, ovf, 0);
    check_val({pfx, "_proto_err"}, proto_err, 0);
    check_val({pfx, "_drop_cnt"}, drop_cnt, 0);
    check_val({pfx, "_state"}, state_dbg, ST_IDLE);
  endtask

  task automatic both_low_error(input logic [7:0] hi);
    step();
    tpa = 1'b1; addr = hi;
    step();
    tpa = 1'b0; mrd_n = 1'b0; mwr_n = 1'b0;
    step();
    mrd_n = 1'b1; mwr_n = 1'b1;
  endtask

  initial begin
    logic [TS_W-1:0] t2;
    wb_rst_i = 1'b1; en = 1'b1; clr = 1'b0; cap_rd = 1'b1; cap_wr = 1'b1;
    tpa = 1'b0; mrd_n = 1'b1; mwr_n = 1'b1; sc = SC_FETCH; n = '0;
    addr = '0; data = '0; rec_ready = 1'b1;
    repeat (3) step();
    check_clean("reset");
    wb_rst_i = 1'b0;
    idle(2);

    // fetch read, also checks the one-cycle record latency
    access(8'h00, 8'h07, SC_FETCH, 3'd1, 1'b0, 8'hF4, 8'hF4, 2, 1'b1, 1'b0);
    check_val("latency_valid", rec_valid, 1);
    check_val("latency_level", level, 1);
    idle(2);

    // execute write keeps the last-low-cycle data
    access(8'h20, 8'h3A, SC_EXEC, 3'd2, 1'b1, 8'h12, 8'h13, 2, 1'b1, 1'b0);
    idle(2);

    // write filtered out
    rec_ready = 1'b0; cap_wr = 1'b0;
    access(8'h20, 8'h3A, SC_EXEC, 3'd2, 1'b1, 8'h12, 8'h13, 2, 1'b0, 1'b0);
    idle(2);
    check_val("filter_level", level, 0);
    cap_wr = 1'b1;

    // capture disabled: the access is never started
    en = 1'b0;
    access(8'h30, 8'h31, SC_FETCH, 3'd0, 1'b0, 8'h5A, 8'h5A, 1, 1'b0, 1'b0);
    check_val("en_level", level, 0);
    check_val("en_state", state_dbg, ST_IDLE);
    en = 1'b1;

    // non-memory cycle: tpa then tpa, no strobe
    step(); tpa = 1'b1; addr = 8'h55;
    step(); tpa = 1'b1; addr = 8'h66;
    idle(2);
    check_val("nonmem_level", level, 0);
    check_val("nonmem_proto_err", proto_err, 0);
    check_val("nonmem_state", state_dbg, ST_ADDR);
    rec_ready = 1'b1;
    access(8'h44, 8'h10, SC_DMA, 3'd3, 1'b0, 8'hC3, 8'hC3, 1, 1'b1, 1'b0);
    idle(2);

    // overflow with consumer stalled
    rec_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      access(8'h80, 8'(i), SC_FETCH, 3'd0, 1'b0, 8'(8'hA0 + i), 8'(8'hA0 + i), 1, i < 4, 1'b0);
    check_val("ovf_level", level, 4);
    check_val("ovf_flag", ovf, 1);
    check_val("ovf_drop_cnt", drop_cnt, 2);
    access(8'h81, 8'h55, SC_INT, 3'd7, 1'b0, 8'h66, 8'h66, 1, 1'b1, 1'b1);
    check_val("fullpp_level", level, 4);
    check_val("fullpp_drop_cnt", drop_cnt, 2);
    rec_ready = 1'b1;
    for (int i = 0; i < 20 && level != 0; i++) step();
    check_val("drain_level", level, 0);
    check_val("drain_queue", exp_q.size(), 0);

    // both strobes low
    rec_ready = 1'b0;
    both_low_error(8'h90);
    idle(1);
    check_val("both_low_err", proto_err, 1);
    check_val("both_low_level", level, 0);
    check_val("both_low_state", state_dbg, ST_IDLE);
    step(); clr = 1'b1;
    step(); clr = 1'b0;
    check_val("clr_err", proto_err, 0);
    check_val("clr_ovf", ovf, 0);

    // tpa during STROBE restarts with the new high byte
    rec_ready = 1'b1;
    step(); tpa = 1'b1; addr = 8'h11; sc = SC_FETCH; n = 3'd0;
    step(); tpa = 1'b0; mrd_n = 1'b0; addr = 8'h22; data = 8'h99;
    step(); tpa = 1'b1; mrd_n = 1'b1; addr = 8'h33; sc = SC_DMA; n = 3'd5; t2 = model_ts;
    step(); tpa = 1'b0; mrd_n = 1'b0; addr = 8'h44; data = 8'hAB;
    step(); mrd_n = 1'b1; addr = '0; data = '0;
    exp_q.push_back({t2, SC_DMA, 1'b0, 3'd5, 8'h33, 8'h44, 8'hAB});
    idle(2);
    check_val("tpa_strobe_err", proto_err, 1);
    check_val("tpa_strobe_level", level, 0);

    // reset in the middle of STROBE
    rec_ready = 1'b0;
    access(8'h70, 8'h01, SC_FETCH, 3'd0, 1'b0, 8'h01, 8'h01, 1, 1'b1, 1'b0);
    check_val("prerst_level", level, 1);
    step(); tpa = 1'b1; addr = 8'h71;
    step(); tpa = 1'b0; mrd_n = 1'b0; addr = 8'h02; data = 8'h77;
    step(); wb_rst_i = 1'b1;
    exp_q.delete();
    step(); wb_rst_i = 1'b0;
    check_clean("rst_mid");
    mrd_n = 1'b1;
    idle(2);
    check_val("rst_mid_after_level", level, 0);

    // clr with three records queued
    for (int i = 0; i < 3; i++)
      access(8'hB0, 8'(i), SC_EXEC, 3'd1, 1'b0, 8'h10, 8'h10, 1, 1'b1, 1'b0);
    check_val("preclr_level", level, 3);
    both_low_error(8'hB5);
    idle(1);
    check_val("preclr_err", proto_err, 1);
    step(); clr = 1'b1;
    exp_q.delete();
    step(); clr = 1'b0;
    check_clean("clr");
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
